// File: rtl/i2s_audio_tx.sv
// I2S transmitter: buffers unsigned 8-bit samples in a small FIFO and sends each one
// as a signed, left-justified mono frame (same word in left and right slots).
// Latency: a queued sample is popped at the next frame start (falling BCLK entering bit 0).
// Backpressure: sample_ready drops while the FIFO is full; an empty FIFO at frame start sends
// mid-scale zeros and pulses underrun for one clk.
// Ports:
//   clk, reset_n                - system clock, asynchronous active-low reset
//   enable                      - 1 runs BCLK/LRCLK, 0 holds the serial side idle
//   sample_data/valid/ready     - sample push interface (push = valid && ready)
//   fifo_level                  - FIFO occupancy
//   i2s_bclk/lrclk/sdata        - serial outputs, data changes on BCLK falling edge
//   underrun                    - one-clk pulse when a frame starts with the FIFO empty
module i2s_audio_tx #(
   parameter int CLK_DIV    = 4,
   parameter int SLOT_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [7:0]                    sample_data,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_sdata,
   output logic                          underrun
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_W);
   localparam int SEL_W = $clog2(SLOT_W);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] LR_FIRST  = BIT_W'(SLOT_W - 1);
   localparam logic [BIT_W-1:0] LR_LAST   = BIT_W'(2 * SLOT_W - 2);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic              run;

   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [SLOT_W-1:0] word;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;

   logic              div_tc, fall_evt, frame_start, push, pop;
   logic [BIT_W-1:0]  bit_nxt, slot_pos;
   logic [SEL_W-1:0]  sel;
   logic [SLOT_W-1:0] word_nxt;
   logic              lrclk_nxt;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable)  state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Serial side advances only on clocks that leave us in RUN; dropping enable
   // clears it on the very next clk.
   assign run = (state_nxt == RUN);

   // ---------------------------------------------------------------- datapath decode
   assign div_tc      = run && (div_cnt == DIV_LAST);
   assign fall_evt    = div_tc && i2s_bclk;
   assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
   assign frame_start = fall_evt && (bit_nxt == '0);

   assign sample_ready = (fifo_level < LVL_FULL);
   assign push         = sample_valid && sample_ready;
   assign pop          = frame_start && (fifo_level != '0);

   // Unsigned -> signed is an MSB flip; the 8 bits are left-justified in the slot.
   always_comb begin
      word_nxt = word;
      if (frame_start) begin
         if (pop) word_nxt = {~mem[rd_ptr][7], mem[rd_ptr][6:0], {(SLOT_W-8){1'b0}}};
         else     word_nxt = '0;
      end
   end

   // Both slots carry the same word, so only the position within a slot matters.
   assign slot_pos  = (bit_nxt >= SLOT_LEN) ? bit_nxt - SLOT_LEN : bit_nxt;
   assign sel       = SEL_W'(SLOT_W - 1) - SEL_W'(slot_pos);
   // LRCLK switches one bit before each slot's MSB (the I2S one-bit delay).
   assign lrclk_nxt = (bit_nxt >= LR_FIRST) && (bit_nxt <= LR_LAST);

   // ---------------------------------------------------------------- serial side
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         bit_cnt   <= BIT_LAST;
         word      <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (!run) begin
            div_cnt   <= '0;
            bit_cnt   <= BIT_LAST;
            word      <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
         end else begin
            if (div_tc) begin
               div_cnt  <= '0;
               i2s_bclk <= ~i2s_bclk;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            if (fall_evt) begin
               bit_cnt   <= bit_nxt;
               word      <= word_nxt;
               i2s_lrclk <= lrclk_nxt;
               i2s_sdata <= word_nxt[sel];
               underrun  <= frame_start && !pop;
            end
         end
      end
   end

   // ---------------------------------------------------------------- sample FIFO
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sample_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Testbench for i2s_audio_tx: a timing-level reference model predicts the
// serial clocks, FIFO occupancy and frame contents; a monitor decodes the
// serial stream at BCLK rising edges and checks each frame against a queue.
module tb_i2s_audio_tx;

   localparam int CD    = 4;
   localparam int SW    = 16;
   localparam int DEPTH = 4;
   localparam int BCLK_P = 2 * CD;          // clk per BCLK period
   localparam int FRAME  = 2 * SW * BCLK_P; // clk per frame

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] sample_data = 8'h00;
   logic       sample_valid = 1'b0;
   logic       sample_ready;
   logic [2:0] fifo_level;
   logic       i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

   i2s_audio_tx #(.CLK_DIV(CD), .SLOT_W(SW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .fifo_level(fifo_level), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
      .i2s_sdata(i2s_sdata), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit mon_on = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   logic [7:0]  mq[$];   // model of queued samples
   logic [15:0] eq[$];   // expected frame words, oldest first
   int  en_cnt = 0;      // enabled clocks since the serial side last left idle
   bit  frame_open = 1'b0;
   int  close_at = 0;
   bit  exp_underrun = 1'b0;

   // Signed mid-scale conversion done arithmetically: (s - 128) scaled to the slot MSBs.
   function automatic logic [15:0] slot_of(input logic [7:0] s);
      int v;
      v = (int'(s) - 128) * 256;
      return v[15:0];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit ready_pre;
      if (!reset_n) begin
         mq.delete();
         eq.delete();
         en_cnt = 0;
         frame_open = 1'b0;
         exp_underrun = 1'b0;
      end else begin
         ready_pre = (mq.size() < DEPTH);
         exp_underrun = 1'b0;
         if (!enable) begin
            if (frame_open) void'(eq.pop_back());   // partially sent frame is lost
            frame_open = 1'b0;
            en_cnt = 0;
         end else begin
            en_cnt++;
            if (en_cnt % BCLK_P == 0 && ((en_cnt / BCLK_P) - 1) % (2 * SW) == 0) begin
               if (mq.size() > 0) eq.push_back(slot_of(mq.pop_front()));
               else begin
                  eq.push_back(16'h0000);
                  exp_underrun = 1'b1;
               end
               frame_open = 1'b1;
               close_at = en_cnt + BCLK_P * (2 * SW - 1) + CD;
            end
            if (frame_open && en_cnt == close_at) frame_open = 1'b0;
         end
         if (sample_valid && ready_pre) mq.push_back(sample_data);
      end
   end

   // ------------------------------------------------------------ per-cycle checks
   always @(negedge clk) begin
      int m, b, exp_lr;
      if (mon_on) begin
         m = en_cnt / BCLK_P;
         b = (m - 1) % (2 * SW);
         exp_lr = (m > 0 && b >= SW - 1 && b <= 2 * SW - 2) ? 1 : 0;
         chk("bclk", i2s_bclk, (en_cnt / CD) % 2);
         chk("lrclk", i2s_lrclk, exp_lr);
         chk("fifo_level", fifo_level, mq.size());
         chk("sample_ready", sample_ready, (mq.size() < DEPTH) ? 1 : 0);
         chk("underrun", underrun, exp_underrun);
         if (en_cnt == 0) chk("idle_sdata", i2s_sdata, 0);
      end
   end

   // ------------------------------------------------------------ frame monitor
   int          rise_n = 0;
   bit          prev_bclk = 1'b0;
   logic [15:0] lw = '0, rw = '0;
   int          frames = 0;

   always @(negedge clk) begin
      int b;
      logic [15:0] exp_w;
      if (en_cnt == 0) begin
         rise_n = 0;
         prev_bclk = 1'b0;
      end else begin
         if (i2s_bclk && !prev_bclk) begin
            rise_n++;
            if (rise_n >= 2) begin
               b = (rise_n - 2) % (2 * SW);
               if (b < SW) lw = {lw[14:0], i2s_sdata};
               else        rw = {rw[14:0], i2s_sdata};
               if (b == 2 * SW - 1 && mon_on) begin
                  frames++;
                  if (eq.size() == 0) chk("frame_expected", 0, 1);
                  else begin
                     exp_w = eq.pop_front();
                     chk("left_slot", lw, exp_w);
                     chk("right_slot", rw, exp_w);
                  end
               end
            end
         end
         prev_bclk = i2s_bclk;
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick(1);
      sample_valid = 1'b0;
   endtask

   initial begin
      int guard;
      logic [7:0] t4 [5];
      t4[0] = 8'h11; t4[1] = 8'h22; t4[2] = 8'h33; t4[3] = 8'h44; t4[4] = 8'h55;

      tick(3);
      chk("rst_bclk", i2s_bclk, 0);
      chk("rst_lrclk", i2s_lrclk, 0);
      chk("rst_sdata", i2s_sdata, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", sample_ready, 1);
      reset_n = 1'b1;
      mon_on = 1'b1;

      // 0xFF frame, then empty-FIFO frames with underrun pulses
      enable = 1'b1;
      push(8'hFF);
      tick(3 * FRAME);

      // mid-scale then minimum
      push(8'h80);
      push(8'h00);
      tick(3 * FRAME);

      // fill while idle: fifth push refused
      enable = 1'b0;
      tick(4);
      for (int i = 0; i < 5; i++) begin
         sample_valid = 1'b1;
         sample_data  = t4[i];
         if (i == 4) begin
            chk("full_ready", sample_ready, 0);
            chk("full_level", fifo_level, 4);
         end
         tick(1);
      end
      sample_valid = 1'b0;
      enable = 1'b1;
      tick(5 * FRAME + 20);

      // drop enable at bit 20 of a frame, then resume with the next sample
      enable = 1'b0;
      tick(2);
      push(8'hA0);
      push(8'hB1);
      push(8'hC2);
      enable = 1'b1;
      guard = 0;
      while (en_cnt != BCLK_P * 21 && guard < 1000) begin
         tick(1);
         guard++;
      end
      chk("bit20_reached", (guard < 1000) ? 1 : 0, 1);
      enable = 1'b0;
      tick(1);
      chk("drop_bclk", i2s_bclk, 0);
      chk("drop_lrclk", i2s_lrclk, 0);
      chk("drop_sdata", i2s_sdata, 0);
      tick(3);
      enable = 1'b1;
      tick(3 * FRAME);

      // asynchronous reset mid-frame with samples queued
      tick(40);
      push(8'h5A);
      push(8'h6B);
      push(8'h7C);
      tick(30);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_level", fifo_level, 0);
      chk("arst_ready", sample_ready, 1);
      chk("arst_bclk", i2s_bclk, 0);
      chk("arst_lrclk", i2s_lrclk, 0);
      chk("arst_sdata", i2s_sdata, 0);
      chk("arst_underrun", underrun, 0);
      tick(3);
      reset_n = 1'b1;
      tick(2 * FRAME);

      // randomized traffic with occasional enable drops
      for (int i = 0; i < 4000; i++) begin
         sample_valid = ($urandom_range(0, 3) == 0);
         sample_data  = 8'($urandom);
         if (enable && $urandom_range(0, 499) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 15) == 0) enable = 1'b1;
         tick(1);
      end

      sample_valid = 1'b0;
      enable = 1'b0;
      tick(4);
      chk("scoreboard_drained", eq.size(), 0);
      chk("frames_seen", (frames >= 20) ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
